// File: rtl/id_ex_stage.sv
// ID/EX holding register with RAW forwarding and ALU operand selection.
// Optional macro ID_EX_FWD_EN enables EX/MEM and MEM/WB forwarding; without it operands come straight from the register file.
package riscv_pkg;
  parameter int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
endpackage

module id_ex_fwd #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rval,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd
);
`ifdef ID_EX_FWD_EN
  // The younger result (EX/MEM) wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd = rval;
    if (exmem_reg_write && exmem_rd == rs && rs != '0)
      fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd == rs && rs != '0)
      fwd = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
  assign fwd = rval;
`endif
endmodule

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  alu_op_t         in_alu_op,
  input  logic            in_src_a_pc,
  input  logic            in_src_b_imm,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            out_ready,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_t         alu_op,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_pc
);
  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [XLEN-1:0]            imm;
    logic [1:0][XLEN-1:0]       rval;
    logic [1:0][RA_W-1:0]       rs;
    logic [RA_W-1:0]            rd;
    alu_op_t                    op;
    logic                       src_a_pc;
    logic                       src_b_imm;
    logic                       reg_write;
  } payload_t;

  payload_t             q, d;
  logic                 valid_q;
  logic                 load;
  logic [1:0][XLEN-1:0] fwd;

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;

  assign d.pc        = in_pc;
  assign d.imm       = in_imm;
  assign d.rval      = {in_rs2_val, in_rs1_val};
  assign d.rs        = {in_rs2, in_rs1};
  assign d.rd        = in_rd;
  assign d.op        = in_alu_op;
  assign d.src_a_pc  = in_src_a_pc;
  assign d.src_b_imm = in_src_b_imm;
  assign d.reg_write = in_reg_write;

  // flush beats a coincident load: the offered instruction is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      q       <= '0;
      q.op    <= ALU_ADD;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (load)      valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (load && !flush) q <= d;
    end
  end

  // Operand 0 is rs1, operand 1 is rs2.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd (
      .rs              (q.rs[g]),
      .rval            (q.rval[g]),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
      .fwd             (fwd[g])
    );
  end

  // An empty stage presents ADD 0,0 so the ALU result is deterministic.
  assign out_valid      = valid_q;
  assign alu_a          = !valid_q ? '0 : (q.src_a_pc  ? q.pc  : fwd[0]);
  assign alu_b          = !valid_q ? '0 : (q.src_b_imm ? q.imm : fwd[1]);
  assign alu_op         = valid_q ? q.op : ALU_ADD;
  assign out_reg_write  = valid_q && q.reg_write;
  assign out_rd         = q.rd;
  assign out_store_data = fwd[1];
  assign out_pc         = q.pc;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed checks from the test plan plus randomized traffic against a behavioural model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_src_a_pc = 0, in_src_b_imm = 0, in_reg_write = 0;
  logic        flush = 0, out_ready = 0, exmem_reg_write = 0, memwb_reg_write = 0;
  logic [31:0] in_pc = 0, in_rs1_val = 0, in_rs2_val = 0, in_imm = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;
  logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0, exmem_rd = 0, memwb_rd = 0;
  alu_op_t     in_alu_op = ALU_ADD;
  logic        in_ready, out_valid, out_reg_write;
  logic [31:0] alu_a, alu_b, out_store_data, out_pc;
  logic [4:0]  out_rd;
  alu_op_t     alu_op;

  int total = 0, bad = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm), .in_reg_write(in_reg_write),
    .flush(flush), .out_ready(out_ready),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_store_data(out_store_data),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction in the stage, if any.
  typedef struct {
    logic [31:0] pc, r1v, r2v, imm;
    logic [4:0]  rs1, rs2, rd;
    alu_op_t     op;
    logic        apc, bimm, rw;
  } ins_t;
  ins_t m;
  bit   mv;
  bit   m_ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv = 0;
    end else begin
      m_ld = in_valid && (!mv || out_ready);
      if (m_ld && !flush)
        m = '{in_pc, in_rs1_val, in_rs2_val, in_imm, in_rs1, in_rs2, in_rd,
              in_alu_op, in_src_a_pc, in_src_b_imm, in_reg_write};
      if (flush)          mv = 0;
      else if (m_ld)      mv = 1;
      else if (out_ready) mv = 0;
    end
  end

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v);
`ifdef ID_EX_FWD_EN
    if (rs != 0 && exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (rs != 0 && memwb_reg_write && memwb_rd == rs) return memwb_result;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !mv || out_ready});
      chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
      chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, mv && m.rw});
      chk("alu_op", {28'b0, alu_op}, mv ? {28'b0, m.op} : {28'b0, ALU_ADD});
      chk("alu_a", alu_a, !mv ? 32'h0 : (m.apc ? m.pc : fwd(m.rs1, m.r1v)));
      chk("alu_b", alu_b, !mv ? 32'h0 : (m.bimm ? m.imm : fwd(m.rs2, m.r2v)));
      if (mv) begin
        chk("out_rd", {27'b0, out_rd}, {27'b0, m.rd});
        chk("out_pc", out_pc, m.pc);
        chk("store_data", out_store_data, fwd(m.rs2, m.r2v));
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                       input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic apc, input logic bimm);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2; in_rs2_val = v2;
    in_imm = imm; in_rd = rd; in_src_a_pc = apc; in_src_b_imm = bimm;
    in_reg_write = 1; in_alu_op = ALU_ADD;
  endtask

  initial begin
    #12;
    look();
    rst_n = 1;
    look();
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst alu_a", alu_a, 32'h0);
    chk("rst alu_b", alu_b, 32'h0);
    chk("rst alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    chk("rst in_ready", {31'b0, in_ready}, 32'h1);

    // Basic ADD, no forwarding match.
    cyc();
    out_ready = 1;
    offer(32'h40, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 5'd7, 0, 0);
    cyc();
    in_valid = 0; out_ready = 0;
    look();
    chk("add out_valid", {31'b0, out_valid}, 32'h1);
    chk("add alu_a", alu_a, 32'h10);
    chk("add alu_b", alu_b, 32'h20);
    chk("add alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});

    // Forward priority on rs1=3.
    cyc();
    out_ready = 1;
    offer(32'h44, 5'd3, 32'h1234, 5'd0, 32'h0, 32'h0, 5'd8, 0, 0);
    cyc();
    in_valid = 0; out_ready = 0;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBBBB;
    look();
`ifdef ID_EX_FWD_EN
    chk("fwd exmem", alu_a, 32'hAAAA);
`else
    chk("fwd exmem", alu_a, 32'h1234);
`endif
    cyc();
    exmem_reg_write = 0;
    look();
`ifdef ID_EX_FWD_EN
    chk("fwd memwb", alu_a, 32'hBBBB);
`else
    chk("fwd memwb", alu_a, 32'h1234);
`endif
    cyc();
    out_ready = 1;
    offer(32'h48, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd9, 0, 0);
    exmem_reg_write = 1; exmem_rd = 0; memwb_reg_write = 0;
    cyc();
    in_valid = 0; out_ready = 0;
    look();
    chk("fwd x0", alu_a, 32'h0);

    // Stall: held instruction (rd=9) must survive three offered cycles.
    cyc();
    exmem_reg_write = 0;
    offer(32'h4C, 5'd1, 32'h55, 5'd2, 32'h66, 32'h0, 5'd12, 0, 0);
    for (int i = 0; i < 3; i++) begin
      look();
      chk("stall in_ready", {31'b0, in_ready}, 32'h0);
      chk("stall out_rd", {27'b0, out_rd}, 32'd9);
      cyc();
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    look();
    chk("stall release rd", {27'b0, out_rd}, 32'd12);
    chk("stall release a", alu_a, 32'h55);

    // Flush coincident with an accepted offer.
    cyc();
    offer(32'h50, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd13, 0, 0);
    flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    look();
    chk("flush out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush reg_write", {31'b0, out_reg_write}, 32'h0);

    // AUIPC-style operand selection.
    cyc();
    offer(32'h100, 5'd1, 32'h11, 5'd6, 32'h77, 32'h2000, 5'd14, 1, 1);
    exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'hCAFE;
    cyc();
    in_valid = 0; out_ready = 0;
    look();
    chk("auipc alu_a", alu_a, 32'h100);
    chk("auipc alu_b", alu_b, 32'h2000);
`ifdef ID_EX_FWD_EN
    chk("auipc store", out_store_data, 32'hCAFE);
`else
    chk("auipc store", out_store_data, 32'h77);
`endif

    // Asynchronous reset discards the held instruction immediately.
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("async out_valid", {31'b0, out_valid}, 32'h0);
    chk("async alu_a", alu_a, 32'h0);
    chk("async reg_write", {31'b0, out_reg_write}, 32'h0);
    look();
    rst_n = 1;

    // Randomized traffic with a small register window to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      in_valid        = ($urandom_range(0, 9) < 7);
      out_ready       = $urandom_range(0, 1);
      flush           = ($urandom_range(0, 7) == 0);
      in_pc           = $urandom; in_imm = $urandom;
      in_rs1_val      = $urandom; in_rs2_val = $urandom;
      in_rs1          = 5'($urandom_range(0, 3));
      in_rs2          = 5'($urandom_range(0, 3));
      in_rd           = 5'($urandom_range(0, 31));
      in_alu_op       = alu_op_t'(4'($urandom_range(0, 9)));
      in_src_a_pc     = $urandom_range(0, 1);
      in_src_b_imm    = $urandom_range(0, 1);
      in_reg_write    = $urandom_range(0, 1);
      exmem_reg_write = $urandom_range(0, 1);
      exmem_rd        = 5'($urandom_range(0, 3));
      exmem_result    = $urandom;
      memwb_reg_write = $urandom_range(0, 1);
      memwb_rd        = 5'($urandom_range(0, 3));
      memwb_result    = $urandom;
    end
    look();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-select stage. It sits directly upstream of the ALU and drives its A, B and ALUControl inputs.
- Captures one decoded instruction per handshake and holds it while EX is stalled. Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, then selects PC/immediate operands.
- Also carries destination and store-data sideband to the EX/MEM stage.

Parameters:
- XLEN, 32, datapath width; matches the riscv_pkg value.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1_val, in_rs2_val  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1, in_rs2, in_rd  in  RA_W  register addresses.
- in_alu_op  in  alu_op_t  ALU operation.
- in_src_a_pc  in  1  1 selects PC for A (AUIPC/JAL).
- in_src_b_imm  in  1  1 selects immediate for B.
- in_reg_write  in  1  instruction writes rd.
- flush  in  1  kill held instruction (branch mispredict/trap).
- out_ready  in  1  EX/MEM accepts this cycle.
- exmem_reg_write, exmem_rd, exmem_result  in  1/RA_W/XLEN  EX/MEM forward source.
- memwb_reg_write, memwb_rd, memwb_result  in  1/RA_W/XLEN  MEM/WB forward source.
- out_valid  out  1  held instruction valid.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_op  out  alu_op_t  drives ALUControl.
- out_rd  out  RA_W  destination register.
- out_reg_write  out  1  gated by out_valid.
- out_store_data  out  XLEN  forwarded rs2 value.
- out_pc  out  XLEN  held PC.

Behaviour:
- One-entry holding register. valid_q and all payload registers reset asynchronously: valid_q=0, payload=0, alu_op register=ALU_ADD.
- in_ready = !valid_q || out_ready (combinational).
- Load condition: in_valid && in_ready. Payload is captured at the next rising edge and valid_q becomes 1. Latency from capture to outputs is one cycle.
- If out_ready && valid_q && !(in_valid && in_ready): valid_q becomes 0.
- If out_ready=0: payload holds and outputs stay stable. Forward values may change as later stages advance.
- flush=1: valid_q becomes 0 next edge, overriding a simultaneous load. The offered instruction is dropped, and in_ready stays as computed.
- Forwarding is combinational on the held rs1/rs2, evaluated per operand:
  - if exmem_reg_write && exmem_rd==rs && rs!=0, use exmem_result;
  - else if memwb_reg_write && memwb_rd==rs && rs!=0, use memwb_result;
  - else use the captured register value.
  - EX/MEM has priority when both match. x0 is never forwarded.
- alu_a = in_src_a_pc ? held PC : fwd_rs1.
- alu_b = in_src_b_imm ? held imm : fwd_rs2.
- out_store_data = fwd_rs2 always.
- When valid_q=0: alu_a=alu_b=0, alu_op=ALU_ADD, out_reg_write=0. This makes the ALU result deterministic (0, Zero=1).
- Load-use hazards are not detected here; the upstream hazard unit withholds in_valid.
- Reset mid-operation discards the held instruction immediately. Outputs go to reset values asynchronously.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: forwarding muxes removed and fwd_rsN = captured values. The exmem_*/memwb_* ports remain but are ignored; the hazard unit must stall instead.
- Handshake, flush and operand selection are identical in both builds.

Test Plan:
- Reset, then release: out_valid=0, alu_a=0, alu_b=0, alu_op=ALU_ADD, in_ready=1.
- Load ADD with rs1=5 (val 0x10) and rs2=6 (val 0x20), no forward match, out_ready=1: next cycle out_valid=1, alu_a=0x10, alu_b=0x20, alu_op=ALU_ADD.
- Forward priority:
  - Held rs1=3 with exmem_rd=3 (0xAAAA) and memwb_rd=3 (0xBBBB), both writing: alu_a=0xAAAA.
  - Drop exmem_reg_write: alu_a=0xBBBB.
  - Set rs1=0 with exmem_rd=0 writing 0xAAAA: alu_a = captured 0.
- Stall: out_ready=0 with in_valid=1 for 3 cycles: in_ready=0, held payload unchanged, no second capture. out_ready=1: new instruction captured the following edge.
- Flush: flush=1 coincident with in_valid=1 and in_ready=1: next cycle out_valid=0 and out_reg_write=0; the offered instruction is dropped.
- Operand selection: AUIPC-style (src_a_pc=1, src_b_imm=1, pc=0x100, imm=0x2000): alu_a=0x100, alu_b=0x2000, out_store_data = forwarded rs2.
